// File: rtl/fft_frame_buffer_if.sv
`default_nettype none
// fft_frame_buffer_if: sample stream into and out of the FFT frame buffer, plus done/err pulses.
// The inverse signal exists only when FFT_CONJ_EN is defined.
interface fft_frame_buffer_if #(
  parameter int DATA_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_sop;
  logic signed [DATA_W-1:0] in_re;
  logic signed [DATA_W-1:0] in_im;
`ifdef FFT_CONJ_EN
  logic                     inverse;
`endif
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_sop;
  logic                     out_eop;
  logic signed [DATA_W-1:0] out_re;
  logic signed [DATA_W-1:0] out_im;
  logic                     done;
  logic                     err;

  // master is the surrounding datapath, slave is the frame buffer.
`ifdef FFT_CONJ_EN
  modport master (
    output in_valid, in_sop, in_re, in_im, inverse, out_ready,
    input  in_ready, out_valid, out_sop, out_eop, out_re, out_im, done, err
  );
  modport slave (
    input  in_valid, in_sop, in_re, in_im, inverse, out_ready,
    output in_ready, out_valid, out_sop, out_eop, out_re, out_im, done, err
  );
`else
  modport master (
    output in_valid, in_sop, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_sop, out_eop, out_re, out_im, done, err
  );
  modport slave (
    input  in_valid, in_sop, in_re, in_im, out_ready,
    output in_ready, out_valid, out_sop, out_eop, out_re, out_im, done, err
  );
`endif
endinterface
`default_nettype wire

// File: rtl/fft_frame_buffer.sv
`default_nettype none
// fft_frame_buffer: ping-pong frame buffer with natural or bit-reversed readout.
// Optional FFT_CONJ_EN macro adds a per-frame conjugate (saturated imag negation) on write.
module fft_frame_buffer #(
  parameter int DATA_W = 16,
  parameter int LOG2N  = 5,
  parameter bit BITREV = 1'b1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  fft_frame_buffer_if.slave bus_if
);
  localparam int               N        = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST_IDX = '1;
  localparam logic [LOG2N-1:0] ONE_IDX  = LOG2N'(1);

  typedef enum logic [1:0] {
    B_EMPTY    = 2'd0,
    B_FILLING  = 2'd1,
    B_FULL     = 2'd2,
    B_DRAINING = 2'd3
  } bank_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME  = 2'd1,
    S_STREAM = 2'd2
  } rd_state_e;

  bank_e                    bank_q [2];
  bank_e                    bank_d [2];
  logic                     wbank_q, wbank_d;
  logic                     rbank_q, rbank_d;
  logic [LOG2N-1:0]         wp_q, wp_d;
  logic [LOG2N-1:0]         rc_q, rc_d;
  rd_state_e                state_q, state_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic signed [DATA_W-1:0] out_re_q, out_im_q;

  logic [2*DATA_W-1:0]      mem_q [2*N];
  logic                     mem_we;
  logic [LOG2N:0]           mem_waddr;
  logic [2*DATA_W-1:0]      mem_wdata;
  logic                     rd_en;
  logic [LOG2N:0]           rd_addr;

  logic                     in_ready_w;
  logic                     accept_w;
  logic                     out_valid_w;
  logic signed [DATA_W-1:0] wr_im_w;

  function automatic logic [LOG2N-1:0] rd_index(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] rev;
    for (int i = 0; i < LOG2N; i++) begin
      rev[i] = idx[LOG2N-1-i];
    end
    return BITREV ? rev : idx;
  endfunction

`ifdef FFT_CONJ_EN
  logic inv_q [2];
  logic inv_d [2];
  logic cur_inv_w;

  // Negating the most negative value would wrap, so it clamps to the positive maximum.
  function automatic logic signed [DATA_W-1:0] neg_sat(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] min_v;
    min_v = {1'b1, {(DATA_W-1){1'b0}}};
    if (x == min_v) begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end
    return -x;
  endfunction

  always_comb begin
    cur_inv_w = bus_if.in_sop ? bus_if.inverse : inv_q[wbank_q];
    wr_im_w   = cur_inv_w ? neg_sat(bus_if.in_im) : bus_if.in_im;
  end
`else
  assign wr_im_w = bus_if.in_im;
`endif

  assign in_ready_w  = (bank_q[wbank_q] == B_EMPTY) || (bank_q[wbank_q] == B_FILLING);
  assign accept_w    = bus_if.in_valid && in_ready_w;
  assign mem_wdata   = {bus_if.in_re, wr_im_w};
  assign out_valid_w = (state_q == S_STREAM);

  always_comb begin
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    wbank_d   = wbank_q;
    wp_d      = wp_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = {wbank_q, wp_q};
    state_d   = state_q;
    rc_d      = rc_q;
    rbank_d   = rbank_q;
    done_d    = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = {rbank_q, rd_index(rc_q)};
`ifdef FFT_CONJ_EN
    inv_d[0]  = inv_q[0];
    inv_d[1]  = inv_q[1];
`endif

    // Write side: a new sop always restarts the current bank at index 0.
    if (accept_w) begin
      if (bus_if.in_sop) begin
        err_d             = (bank_q[wbank_q] == B_FILLING) && (wp_q != '0);
        mem_we            = 1'b1;
        mem_waddr         = {wbank_q, {LOG2N{1'b0}}};
        wp_d              = ONE_IDX;
        bank_d[wbank_q]   = B_FILLING;
`ifdef FFT_CONJ_EN
        inv_d[wbank_q]    = bus_if.inverse;
`endif
      end else if (bank_q[wbank_q] == B_FILLING) begin
        mem_we    = 1'b1;
        mem_waddr = {wbank_q, wp_q};
        if (wp_q == LAST_IDX) begin
          bank_d[wbank_q] = B_FULL;
          wbank_d         = !wbank_q;
          wp_d            = '0;
        end else begin
          wp_d = wp_q + ONE_IDX;
        end
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (bank_q[rbank_q] == B_FULL) begin
          bank_d[rbank_q] = B_DRAINING;
          rc_d            = '0;
          state_d         = S_PRIME;
        end
      end
      S_PRIME: begin
        rd_en   = 1'b1;
        rd_addr = {rbank_q, rd_index(rc_q)};
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (bus_if.out_ready) begin
          if (rc_q == LAST_IDX) begin
            bank_d[rbank_q] = B_EMPTY;
            done_d          = 1'b1;
            rbank_d         = !rbank_q;
            rc_d            = '0;
            if (bank_q[!rbank_q] == B_FULL) begin
              bank_d[!rbank_q] = B_DRAINING;
              state_d          = S_PRIME;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            // Prefetch the next entry so the stream has no bubbles.
            rc_d    = rc_q + ONE_IDX;
            rd_en   = 1'b1;
            rd_addr = {rbank_q, rd_index(rc_q + ONE_IDX)};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q[0] <= B_EMPTY;
      bank_q[1] <= B_EMPTY;
      wbank_q   <= 1'b0;
      rbank_q   <= 1'b0;
      wp_q      <= '0;
      rc_q      <= '0;
      state_q   <= S_IDLE;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      out_re_q  <= '0;
      out_im_q  <= '0;
`ifdef FFT_CONJ_EN
      inv_q[0]  <= 1'b0;
      inv_q[1]  <= 1'b0;
`endif
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      wbank_q   <= wbank_d;
      rbank_q   <= rbank_d;
      wp_q      <= wp_d;
      rc_q      <= rc_d;
      state_q   <= state_d;
      done_q    <= done_d;
      err_q     <= err_d;
      if (rd_en) begin
        {out_re_q, out_im_q} <= mem_q[rd_addr];
      end
`ifdef FFT_CONJ_EN
      inv_q[0]  <= inv_d[0];
      inv_q[1]  <= inv_d[1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus_if.in_ready  = in_ready_w;
  assign bus_if.out_valid = out_valid_w;
  assign bus_if.out_sop   = out_valid_w && (rc_q == '0);
  assign bus_if.out_eop   = out_valid_w && (rc_q == LAST_IDX);
  assign bus_if.out_re    = out_re_q;
  assign bus_if.out_im    = out_im_q;
  assign bus_if.done      = done_q;
  assign bus_if.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_buffer.sv
`default_nettype none
// tb_fft_frame_buffer: two LOG2N=3 buffers (bit-reversed A, natural B) driven in lockstep,
// table-driven frame vectors plus hand-written stall, backpressure, framing-error and reset sequences.
module tb_fft_frame_buffer;
  typedef struct {
    int re_in;
    int im_in;
    int a_re;
    int a_im;
    int b_re;
    int b_im;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cur_inv = 1'b0;
  logic mon_en = 1'b0;
  int   n_pass = 0;
  int   n_tot = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   br [8];

  int cap_a_re[$], cap_a_im[$], cap_a_sop[$], cap_a_eop[$], cap_b_re[$], cap_b_im[$];
  int exp_a_re[$], exp_a_im[$], exp_b_re[$], exp_b_im[$];

  logic hold_pend = 1'b0;
  logic eop_pend = 1'b0;
  int   held_re = 0;
  int   held_im = 0;

  always #5 clk = ~clk;

  fft_frame_buffer_if #(.DATA_W(16)) ifa ();
  fft_frame_buffer_if #(.DATA_W(16)) ifb ();

  fft_frame_buffer #(.DATA_W(16), .LOG2N(3), .BITREV(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus_if(ifa)
  );
  fft_frame_buffer #(.DATA_W(16), .LOG2N(3), .BITREV(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus_if(ifb)
  );

  assign ifb.in_valid  = ifa.in_valid;
  assign ifb.in_sop    = ifa.in_sop;
  assign ifb.in_re     = ifa.in_re;
  assign ifb.in_im     = ifa.in_im;
  assign ifb.out_ready = ifa.out_ready;
`ifdef FFT_CONJ_EN
  assign ifb.inverse   = ifa.inverse;
`endif

  task automatic chk(input string nm, input int act, input int req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0d, required %0d", nm, act, req);
  endtask

  // Sampled mid-cycle: a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (hold_pend && ifa.out_valid === 1'b1) begin
        chk("hold_re", int'(ifa.out_re), held_re);
        chk("hold_im", int'(ifa.out_im), held_im);
      end
      if (eop_pend) chk("done_after_eop", int'(ifa.done), 1);
      eop_pend  = ifa.out_valid && ifa.out_ready && ifa.out_eop;
      hold_pend = ifa.out_valid && !ifa.out_ready;
      held_re   = int'(ifa.out_re);
      held_im   = int'(ifa.out_im);
      if (ifa.out_valid && ifa.out_ready) begin
        cap_a_re.push_back(int'(ifa.out_re));
        cap_a_im.push_back(int'(ifa.out_im));
        cap_a_sop.push_back(int'(ifa.out_sop));
        cap_a_eop.push_back(int'(ifa.out_eop));
      end
      if (ifb.out_valid && ifb.out_ready) begin
        cap_b_re.push_back(int'(ifb.out_re));
        cap_b_im.push_back(int'(ifb.out_im));
      end
      if (ifa.done) done_cnt++;
      if (ifa.err) err_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int re, input int im, input logic sop);
    int t;
    t = 0;
    ifa.in_valid = 1'b1;
    ifa.in_sop   = sop;
    ifa.in_re    = 16'(re);
    ifa.in_im    = 16'(im);
`ifdef FFT_CONJ_EN
    ifa.inverse  = cur_inv;
`endif
    while (ifa.in_ready !== 1'b1 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("push_in_ready", int'(ifa.in_ready), 1);
    @(posedge clk);
    #1;
    ifa.in_valid = 1'b0;
    ifa.in_sop   = 1'b0;
  endtask

  task automatic mk_frame(input int base, output vec_t v [8]);
    for (int i = 0; i < 8; i++) begin
      v[i] = '{base + i, -(base + i), base + br[i], -(base + br[i]), base + i, -(base + i)};
    end
  endtask

  task automatic push_frame(input vec_t v [8]);
    for (int i = 0; i < 8; i++) push(v[i].re_in, v[i].im_in, (i == 0));
  endtask

  task automatic expect_frame(input vec_t v [8]);
    for (int i = 0; i < 8; i++) begin
      exp_a_re.push_back(v[i].a_re);
      exp_a_im.push_back(v[i].a_im);
      exp_b_re.push_back(v[i].b_re);
      exp_b_im.push_back(v[i].b_im);
    end
  endtask

  task automatic wait_caps(input int n);
    int t;
    t = 0;
    while (cap_a_re.size() < n && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    cyc(3);
  endtask

  task automatic check_stream(input string nm);
    chk({nm, "_count_a"}, cap_a_re.size(), exp_a_re.size());
    chk({nm, "_count_b"}, cap_b_re.size(), exp_b_re.size());
    for (int i = 0; i < exp_a_re.size(); i++) begin
      if (i < cap_a_re.size()) begin
        chk($sformatf("%s_a_re[%0d]", nm, i), cap_a_re[i], exp_a_re[i]);
        chk($sformatf("%s_a_im[%0d]", nm, i), cap_a_im[i], exp_a_im[i]);
        chk($sformatf("%s_a_sop[%0d]", nm, i), cap_a_sop[i], int'(i % 8 == 0));
        chk($sformatf("%s_a_eop[%0d]", nm, i), cap_a_eop[i], int'(i % 8 == 7));
      end
      if (i < cap_b_re.size()) begin
        chk($sformatf("%s_b_re[%0d]", nm, i), cap_b_re[i], exp_b_re[i]);
        chk($sformatf("%s_b_im[%0d]", nm, i), cap_b_im[i], exp_b_im[i]);
      end
    end
    cap_a_re.delete(); cap_a_im.delete(); cap_a_sop.delete(); cap_a_eop.delete();
    cap_b_re.delete(); cap_b_im.delete();
    exp_a_re.delete(); exp_a_im.delete(); exp_b_re.delete(); exp_b_im.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t1 [8];
    vec_t tc [8];
    vec_t f0 [8];
    vec_t f1 [8];
    vec_t f2 [8];
    int   err0;
    int   done0;

    br = '{0, 4, 2, 6, 1, 5, 3, 7};
    // {re_in, im_in, A re, A im, B re, B im}: A is bit-reversed order, B natural.
    t1[0] = '{0,  0, 0,  0, 0,  0};
    t1[1] = '{1, -1, 4, -4, 1, -1};
    t1[2] = '{2, -2, 2, -2, 2, -2};
    t1[3] = '{3, -3, 6, -6, 3, -3};
    t1[4] = '{4, -4, 1, -1, 4, -4};
    t1[5] = '{5, -5, 5, -5, 5, -5};
    t1[6] = '{6, -6, 3, -3, 6, -6};
    t1[7] = '{7, -7, 7, -7, 7, -7};
    // Conjugated frame: imag outputs are the saturated negation of the inputs.
    tc[0] = '{0, -32768, 0,  32767, 0,  32767};
    tc[1] = '{1,    100, 4, -32767, 1,   -100};
    tc[2] = '{2,      0, 2,      0, 2,      0};
    tc[3] = '{3,     -5, 6,      1, 3,      5};
    tc[4] = '{4,  32767, 1,   -100, 4, -32767};
    tc[5] = '{5,      1, 5,     -1, 5,     -1};
    tc[6] = '{6,     -1, 3,      5, 6,      1};
    tc[7] = '{7,      7, 7,     -7, 7,     -7};

    ifa.in_valid  = 1'b0;
    ifa.in_sop    = 1'b0;
    ifa.in_re     = '0;
    ifa.in_im     = '0;
    ifa.out_ready = 1'b1;
`ifdef FFT_CONJ_EN
    ifa.inverse   = 1'b0;
`endif

    // Reset values
    cyc(3);
    chk("rst_in_ready", int'(ifa.in_ready), 1);
    chk("rst_out_valid", int'(ifa.out_valid), 0);
    chk("rst_out_sop", int'(ifa.out_sop), 0);
    chk("rst_out_eop", int'(ifa.out_eop), 0);
    chk("rst_done", int'(ifa.done), 0);
    chk("rst_err", int'(ifa.err), 0);
    chk("rst_out_re", int'(ifa.out_re), 0);
    chk("rst_out_im", int'(ifa.out_im), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    cyc(2);

    // Basic frame and first-output latency
    for (int i = 0; i < 8; i++) push(t1[i].re_in, t1[i].im_in, (i == 0));
    chk("lat_e0_valid", int'(ifa.out_valid), 0);
    cyc(1);
    chk("lat_e1_valid", int'(ifa.out_valid), 0);
    cyc(1);
    chk("lat_e2_valid", int'(ifa.out_valid), 1);
    chk("lat_e2_sop", int'(ifa.out_sop), 1);
    chk("lat_e2_re", int'(ifa.out_re), 0);
    expect_frame(t1);
    wait_caps(8);
    check_stream("t1");
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_err_cnt", err_cnt, 0);

    // Three back-to-back frames with out_ready toggling every cycle
    mk_frame(16, f0);
    mk_frame(32, f1);
    mk_frame(48, f2);
    expect_frame(f0);
    expect_frame(f1);
    expect_frame(f2);
    fork
      begin
        push_frame(f0);
        push_frame(f1);
        push_frame(f2);
      end
      begin
        for (int c = 0; c < 600 && cap_a_re.size() < 24; c++) begin
          @(posedge clk);
          #1;
          ifa.out_ready = ~ifa.out_ready;
        end
      end
    join
    ifa.out_ready = 1'b1;
    wait_caps(24);
    check_stream("t2");
    chk("t2_done_cnt", done_cnt, 4);

    // Backpressure: both banks occupied
    ifa.out_ready = 1'b0;
    mk_frame(64, f0);
    mk_frame(80, f1);
    expect_frame(f0);
    expect_frame(f1);
    push_frame(f0);
    for (int i = 0; i < 8; i++) begin
      push(f1[i].re_in, f1[i].im_in, (i == 0));
      if (i == 6) chk("bp_ready_after_15", int'(ifa.in_ready), 1);
      if (i == 7) chk("bp_ready_after_16", int'(ifa.in_ready), 0);
    end
    cyc(3);
    chk("bp_stalled_valid", int'(ifa.out_valid), 1);
    chk("bp_ready_stalled", int'(ifa.in_ready), 0);
    ifa.out_ready = 1'b1;
    cyc(1);
    ifa.out_ready = 1'b0;
    cyc(3);
    chk("bp_ready_after_one_hs", int'(ifa.in_ready), 0);
    ifa.out_ready = 1'b1;
    for (int t = 0; t < 50 && !(ifa.out_valid && ifa.out_eop); t++) cyc(1);
    chk("bp_eop_reached", int'(ifa.out_eop), 1);
    chk("bp_ready_before_eop_hs", int'(ifa.in_ready), 0);
    cyc(1);
    chk("bp_ready_after_eop_hs", int'(ifa.in_ready), 1);
    wait_caps(16);
    check_stream("t3");

    // Framing errors: stray sample with no open frame, then sop at wp=5
    err0 = err_cnt;
    push(1, 1, 1'b0);
    cyc(3);
    chk("drop_err_cnt", err_cnt - err0, 1);
    chk("drop_no_output", cap_a_re.size(), 0);
    err0 = err_cnt;
    for (int i = 0; i < 5; i++) push(900 + i, 0, (i == 0));
    mk_frame(200, f0);
    expect_frame(f0);
    push_frame(f0);
    wait_caps(8);
    chk("restart_err_cnt", err_cnt - err0, 1);
    check_stream("t4");

`ifdef FFT_CONJ_EN
    // Conjugated frame
    cur_inv = 1'b1;
    push_frame(tc);
    cur_inv = 1'b0;
    expect_frame(tc);
    wait_caps(8);
    check_stream("t5");
`endif

    // Asynchronous reset mid-frame while a previous frame is stalled at the output
    ifa.out_ready = 1'b0;
    mk_frame(300, f0);
    push_frame(f0);
    cyc(4);
    chk("prerst_valid", int'(ifa.out_valid), 1);
    chk("prerst_re", int'(ifa.out_re), 300);
    push(500, -500, 1'b1);
    push(501, -501, 1'b0);
    push(502, -502, 1'b0);
    done0 = done_cnt;
    err0  = err_cnt;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_in_ready", int'(ifa.in_ready), 1);
    chk("arst_out_valid", int'(ifa.out_valid), 0);
    chk("arst_out_sop", int'(ifa.out_sop), 0);
    chk("arst_out_re", int'(ifa.out_re), 0);
    chk("arst_out_im", int'(ifa.out_im), 0);
    chk("arst_b_valid", int'(ifb.out_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(2);
    chk("postrst_valid", int'(ifa.out_valid), 0);
    ifa.out_ready = 1'b1;
    mk_frame(700, f1);
    expect_frame(f1);
    push_frame(f1);
    wait_caps(8);
    check_stream("t6");
    chk("t6_done_delta", done_cnt - done0, 1);
    chk("t6_err_delta", err_cnt - err0, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fft_frame_buffer.md
# fft_frame_buffer

Parametrised frame buffer and reorder stage placed in front of or behind the radix-2 FFT core, in place of the fixed 32-point, start/done-only wrapper. Accepts complex samples in frames of 2^LOG2N with valid/ready handshakes on both sides. Ping-pong banking lets one frame be written while the previous one is read. Read order is natural or bit-reversed, and an optional conjugate path lets a forward core compute the IFFT.

## Interface
Parameters:
- DATA_W, 16, width of each signed real/imag component
- LOG2N, 5, log2 of frame length N (N=32 default; legal 2..10)
- BITREV, 1, 1 = output in bit-reversed index order, 0 = natural order

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  buffer can accept a sample
- in_sop  in  1  first sample of a frame (qualified by in_valid)
- in_re, in_im  in  DATA_W  signed input sample
- inverse  in  1  conjugate frame (only with FFT_CONJ_EN; sampled with in_sop)
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts sample
- out_sop, out_eop  out  1  first/last sample of output frame
- out_re, out_im  out  DATA_W  signed output sample
- done  out  1  one-cycle pulse when out_eop is handshaken
- err  out  1  one-cycle pulse on framing error

## Operation
- Two banks of N entries each: bank state EMPTY, FILLING, FULL or DRAINING. Write pointer wp[LOG2N-1:0]. Read counter rc[LOG2N-1:0].
- Write side:
  - in_ready = 1 when the current write bank is EMPTY or FILLING.
  - The accept condition is in_valid & in_ready.
  - Accepting a sample with in_sop forces wp = 0 and the bank to FILLING.
  - Samples arriving while no frame is open and without in_sop are dropped; err pulses.
  - in_sop while FILLING with wp≠0 pulses err. The partial frame is discarded and the new frame starts at wp = 0 with the same sample.
  - Accepting with wp = N-1 marks the bank FULL and toggles the write bank.
- Read FSM, states IDLE, PRIME and STREAM:
  - IDLE→PRIME when the read bank is FULL; the bank becomes DRAINING.
  - PRIME issues a memory read of address f(rc), where f(rc) = bit-reverse(rc) if BITREV, else rc.
  - PRIME→STREAM: out_valid asserted.
  - In STREAM, out_valid && !out_ready holds all outputs stable.
  - A handshake advances rc and prefetches the next address, so the output stream has no bubbles under continuous out_ready.
  - Handshake at rc = N-1: the bank goes EMPTY, done pulses, and the read bank toggles. The FSM goes to PRIME if the other bank is FULL, else to IDLE.
- out_sop = (rc == 0) and out_eop = (rc == N-1), both qualified by out_valid.
- A bank being DRAINING never blocks writes to the other bank. A write bank becomes writable in the same cycle its drain completes.
- Reset mid-operation: all banks go EMPTY, the FSM goes to IDLE, and in-flight frames are lost. Memory contents are not cleared.

## Timing
- Reset values:
  - in_ready = 1
  - out_valid, out_sop, out_eop, done, err = 0
  - out_re, out_im = 0
  - FSM in IDLE, wp and rc = 0, write and read bank = 0
- Latency: the last input sample is accepted at edge E; out_valid with out_sop is high after edge E+2, when out_ready is held high.
- Throughput: 1 sample/cycle sustained on both sides.
- Both banks FULL or DRAINING: in_ready = 0 until the drain completes.
- done and err are registered one-cycle pulses, asserted the cycle after the triggering edge.

## Configuration
- FFT_CONJ_EN defined:
  - The inverse port exists and is latched per frame at in_sop.
  - When set, the stored imag value is -in_im, saturated: -(-2^(DATA_W-1)) becomes 2^(DATA_W-1)-1.
  - The latched flag travels with the bank and is not user-visible.
- FFT_CONJ_EN undefined: the inverse port is absent, and data is stored unmodified.

## Test plan
- LOG2N=3, BITREV=1: frame with re=k, im=-k for k=0..7, out_ready=1 -> output re order 0,4,2,6,1,5,3,7. out_sop on the first, out_eop and done on the last; out_valid 2 cycles after the 8th input.
- BITREV=0: three back-to-back frames, out_ready toggling 1/0 every cycle -> all 24 samples in natural order, no loss or duplication, outputs held while stalled.
- out_ready=0: write two full frames -> in_ready drops after the 16th accept. A single out_ready handshake doesn't reopen it; it rises in the cycle after the first frame's eop handshake.
- in_sop at wp=5 -> err pulses once, and the new frame output contains only samples from the second sop onward.
- FFT_CONJ_EN with inverse=1: im=-32768, 100, 0 -> out_im = 32767, -100, 0, with out_re unchanged.
- Assert rst for one cycle mid-frame, after 3 samples written -> all outputs return to reset values asynchronously. The next full frame outputs correctly with no residue.
